avl_uart: RTL and testbench

- Avalon-MM slave UART sitting directly downstream of the SoC interconnect's exported `uart_*` master port (5-bit byte address, 32-bit data, burstcount 1).
- Holds a TX FIFO, an RX FIFO, a programmable baud divider, TX/RX serial state machines and an interrupt output.
- Provides the console/serial path for the RISC-V core on DE10-Lite.

---
 rtl/avl_uart_pkg.sv | 56 +++++
 rtl/avl_uart_fifo.sv | 50 +++++
 rtl/avl_uart.sv | 347 ++++++++++++++++++++++++++++++++++
 tb/tb_avl_uart.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/avl_uart_pkg.sv
// avl_uart_pkg: shared definitions for the Avalon-MM UART.
//   - register word indices (avl_address[4:2])
//   - STATUS / CTRL bit positions and the writable CTRL mask
//   - TX / RX serial state encodings
// Optional feature macro: UART_PARITY_EN (adds CTRL.par_en, STATUS.par_err
// and the PARITY states).
package avl_uart_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_DIV    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_OVERRUN  = 4;
  localparam int unsigned ST_FRAME    = 5;
  localparam int unsigned ST_TX_BUSY  = 6;
  localparam int unsigned ST_PAR_ERR  = 7;

  localparam int unsigned CT_TX_EN  = 0;
  localparam int unsigned CT_RX_EN  = 1;
  localparam int unsigned CT_RX_IE  = 2;
  localparam int unsigned CT_TX_IE  = 3;
  localparam int unsigned CT_PAR_EN = 4;

  localparam logic [4:0] CTRL_RESET = 5'h03;
`ifdef UART_PARITY_EN
  localparam logic [4:0] CTRL_MASK  = 5'h1F;
`else
  localparam logic [4:0] CTRL_MASK  = 5'h0F;
`endif

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3
`ifdef UART_PARITY_EN
    , TX_PARITY = 3'd4
`endif
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3
`ifdef UART_PARITY_EN
    , RX_PARITY = 3'd4
`endif
  } rx_state_t;

endpackage

// File: rtl/avl_uart_fifo.sv
// uart_fifo: synchronous FIFO used for both UART directions.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request / data (ignored when full, unless popping)
//   pop, dout     read request / head-of-queue data (show-ahead)
//   full, empty   status, derived from pointer MSB comparison
// A simultaneous pop and push on a full FIFO is treated as pop-then-push.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/avl_uart.sv
// avl_uart: Avalon-MM slave UART (8N1, optional even parity).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   avl_address[4:0]          byte address, [4:2] selects DATA/STATUS/DIV/CTRL
//   avl_read, avl_write       requests (write wins when both asserted)
//   avl_writedata, avl_byteenable
//   avl_burstcount, avl_debugaccess   ignored
//   avl_waitrequest           tied low
//   avl_readdata, avl_readdatavalid   one-cycle read latency
//   uart_rxd, uart_txd        serial line
//   irq                       registered level interrupt
// Optional feature macro: UART_PARITY_EN.
module avl_uart
  import avl_uart_pkg::*;
#(
  parameter int unsigned        FIFO_DEPTH = 16,
  parameter int unsigned        DIV_W      = 16,
  parameter logic [DIV_W-1:0]   DIV_RESET  = DIV_W'(434)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  avl_address,
  input  logic        avl_read,
  input  logic        avl_write,
  input  logic [31:0] avl_writedata,
  input  logic [3:0]  avl_byteenable,
  input  logic        avl_burstcount,
  input  logic        avl_debugaccess,
  output logic        avl_waitrequest,
  output logic [31:0] avl_readdata,
  output logic        avl_readdatavalid,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        irq
);

  logic             wr, rd;
  logic [2:0]       reg_sel;
  logic [DIV_W-1:0] div_q, div_wr, div_fixed;
  logic [4:0]       ctrl_q;
  logic [7:0]       status;
  logic [31:0]      rdata_next;
  logic             overrun_q, frame_q, par_err_q;
  logic             unused_ok;

  logic             tx_push, tx_pop, tx_full, tx_empty, tx_load;
  logic [7:0]       tx_dout;
  tx_state_t        tx_state;
  logic [DIV_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;
  logic             txd_q;

  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_dout;
  rx_state_t        rx_state;
  logic [DIV_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             rx_meta, rx_sync, rx_prev;
  logic             rx_stop_tick, rx_good, par_bad;
  logic             overrun_set, frame_set;

  assign unused_ok = ^{avl_burstcount, avl_debugaccess, avl_address[1:0],
                       avl_writedata, avl_byteenable};

  // Bus decode
  assign avl_waitrequest = 1'b0;
  assign reg_sel = avl_address[4:2];
  assign wr      = avl_write;
  assign rd      = avl_read && !avl_write;

  always_comb begin
    div_wr = div_q;
    for (int unsigned i = 0; i < DIV_W; i++) begin
      if (avl_byteenable[i/8]) div_wr[i] = avl_writedata[i];
    end
    div_fixed = (div_wr < DIV_W'(2)) ? DIV_W'(2) : div_wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= DIV_RESET;
      ctrl_q <= CTRL_RESET;
    end else if (wr) begin
      case (reg_sel)
        REG_DIV:  div_q <= div_fixed;
        REG_CTRL: if (avl_byteenable[0]) ctrl_q <= avl_writedata[4:0] & CTRL_MASK;
        default:  ;
      endcase
    end
  end

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_OVERRUN]  = overrun_q;
    status[ST_FRAME]    = frame_q;
    status[ST_TX_BUSY]  = (tx_state != TX_IDLE);
    status[ST_PAR_ERR]  = par_err_q;
  end

  always_comb begin
    rdata_next = '0;
    case (reg_sel)
      REG_DATA:   rdata_next = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_dout};
      REG_STATUS: rdata_next = {24'b0, status};
      REG_DIV:    rdata_next = 32'(div_q);
      REG_CTRL:   rdata_next = {27'b0, ctrl_q};
      default:    rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avl_readdata      <= '0;
      avl_readdatavalid <= 1'b0;
    end else begin
      avl_readdata      <= rd ? rdata_next : '0;
      avl_readdatavalid <= rd;
    end
  end

  // Sticky error flags: a set in the same cycle as the clearing read wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      overrun_q <= (overrun_q && !(rd && reg_sel == REG_STATUS)) || overrun_set;
      frame_q   <= (frame_q   && !(rd && reg_sel == REG_STATUS)) || frame_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= (ctrl_q[CT_RX_IE] && !rx_empty) || (ctrl_q[CT_TX_IE] && tx_empty);
  end

  // TX path
  assign tx_push = wr && (reg_sel == REG_DATA) && avl_byteenable[0];
  assign tx_load = ctrl_q[CT_TX_EN] && !tx_empty &&
                   ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == '0));
  assign tx_pop  = tx_load;
  assign uart_txd = txd_q;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (avl_writedata[7:0]),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

`ifdef UART_PARITY_EN
  logic tx_par;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          tx_par <= 1'b0;
    else if (tx_load) tx_par <= ^tx_dout;
  end
`endif

  // txd_q is updated together with the state so the line changes exactly
  // on bit boundaries; the divisor is sampled at each boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tx_state <= TX_START;
            tx_cnt   <= div_q - DIV_W'(1);
            tx_shreg <= tx_dout;
            txd_q    <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= div_q - DIV_W'(1);
            tx_bit   <= '0;
            txd_q    <= tx_shreg[0];
          end else tx_cnt <= tx_cnt - DIV_W'(1);
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= div_q - DIV_W'(1);
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              if (ctrl_q[CT_PAR_EN]) begin
                tx_state <= TX_PARITY;
                txd_q    <= tx_par;
              end else
`endif
              begin
                tx_state <= TX_STOP;
                txd_q    <= 1'b1;
              end
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shreg <= tx_shreg >> 1;
              txd_q    <= tx_shreg[1];
            end
          end else tx_cnt <= tx_cnt - DIV_W'(1);
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_STOP;
            tx_cnt   <= div_q - DIV_W'(1);
            txd_q    <= 1'b1;
          end else tx_cnt <= tx_cnt - DIV_W'(1);
        end
`endif
        TX_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_load) begin
              tx_state <= TX_START;
              tx_cnt   <= div_q - DIV_W'(1);
              tx_shreg <= tx_dout;
              txd_q    <= 1'b0;
            end else tx_state <= TX_IDLE;
          end else tx_cnt <= tx_cnt - DIV_W'(1);
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

`ifdef UART_PARITY_EN
  logic rx_par_bit, rx_par_used, par_set;
  assign par_bad = rx_par_used && ((^rx_shreg) != rx_par_bit);
  assign par_set = rx_stop_tick && rx_sync && par_bad;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= (par_err_q && !(rd && reg_sel == REG_STATUS)) || par_set;
  end
`else
  assign par_bad   = 1'b0;
  assign par_err_q = 1'b0;
`endif

  // CPU pop is applied before the RX push, so a full FIFO being read
  // still accepts the incoming byte without an overrun.
  assign rx_stop_tick = (rx_state == RX_STOP) && (rx_cnt == '0);
  assign rx_good      = rx_stop_tick && rx_sync && !par_bad;
  assign rx_pop       = rd && (reg_sel == REG_DATA) && !rx_empty;
  assign rx_push      = rx_good && (!rx_full || rx_pop);
  assign overrun_set  = rx_good && rx_full && !rx_pop;
  assign frame_set    = rx_stop_tick && !rx_sync;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_shreg),
    .pop   (rx_pop),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
`ifdef UART_PARITY_EN
      rx_par_bit  <= 1'b0;
      rx_par_used <= 1'b0;
`endif
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (ctrl_q[CT_RX_EN] && rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= (div_q >> 1) - DIV_W'(1);
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (rx_sync) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_cnt   <= div_q - DIV_W'(1);
              rx_bit   <= '0;
            end
          end else rx_cnt <= rx_cnt - DIV_W'(1);
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shreg <= {rx_sync, rx_shreg[7:1]};
            rx_cnt   <= div_q - DIV_W'(1);
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_par_used <= ctrl_q[CT_PAR_EN];
              if (ctrl_q[CT_PAR_EN]) rx_state <= RX_PARITY;
              else
`endif
              rx_state <= RX_STOP;
            end else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - DIV_W'(1);
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == '0) begin
            rx_par_bit <= rx_sync;
            rx_state   <= RX_STOP;
            rx_cnt     <= div_q - DIV_W'(1);
          end else rx_cnt <= rx_cnt - DIV_W'(1);
        end
`endif
        RX_STOP: begin
          if (rx_cnt == '0) rx_state <= RX_IDLE;
          else              rx_cnt   <= rx_cnt - DIV_W'(1);
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avl_uart.sv
// tb_avl_uart: directed self-checking bench for avl_uart (default build).
module tb_avl_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  avl_address = '0;
  logic        avl_read = 1'b0;
  logic        avl_write = 1'b0;
  logic [31:0] avl_writedata = '0;
  logic [3:0]  avl_byteenable = 4'hF;
  logic        avl_waitrequest;
  logic [31:0] avl_readdata;
  logic        avl_readdatavalid;
  logic        uart_rxd;
  logic        uart_txd;
  logic        irq;
  logic        loop_en = 1'b0;
  logic        rxd_drv = 1'b1;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] A_DATA = 5'h00, A_STATUS = 5'h04, A_DIV = 5'h08,
                         A_CTRL = 5'h0C, A_RSVD = 5'h14;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  avl_uart #(.FIFO_DEPTH(16), .DIV_W(16), .DIV_RESET(16'd434)) dut (
    .clk               (clk),
    .rst               (rst),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_byteenable    (avl_byteenable),
    .avl_burstcount    (1'b1),
    .avl_debugaccess   (1'b0),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid),
    .uart_rxd          (uart_rxd),
    .uart_txd          (uart_txd),
    .irq               (irq)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic avl_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avl_address = a; avl_writedata = d; avl_byteenable = be; avl_write = 1'b1;
    @(negedge clk);
    avl_write = 1'b0;
  endtask

  task automatic avl_rd(input logic [4:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    avl_address = a; avl_read = 1'b1;
    @(negedge clk);
    avl_read = 1'b0;
    d = avl_readdata;
    v = avl_readdatavalid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic        v;
    logic        found;
    logic [39:0] txs, txe;
    logic [9:0]  frame;
    logic [9:0]  bad_frame;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle after making state non-default
    avl_wr(A_DIV, 32'd4, 4'hF);
    avl_wr(A_CTRL, 32'h0B, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_before_reset", 64'(irq), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_txd", 64'(uart_txd), 64'd1);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_rdv", 64'(avl_readdatavalid), 64'd0);
    check("rst_waitreq", 64'(avl_waitrequest), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Read latency: valid exactly one cycle after acceptance
    @(negedge clk);
    check("lat_rdv_n", 64'(avl_readdatavalid), 64'd0);
    avl_address = A_DIV; avl_read = 1'b1;
    @(negedge clk);
    avl_read = 1'b0;
    check("lat_rdv_n1", 64'(avl_readdatavalid), 64'd1);
    check("lat_div_reset", 64'(avl_readdata), 64'h1B2);
    @(negedge clk);
    check("lat_rdv_n2", 64'(avl_readdatavalid), 64'd0);

    avl_rd(A_CTRL, d, v);
    check("ctrl_reset", 64'(d), 64'h3);
    check("ctrl_reset_valid", 64'(v), 64'd1);

    // DIV boundary: 1 stored as 2, per-lane write
    avl_wr(A_DIV, 32'd1, 4'hF);
    avl_rd(A_DIV, d, v);
    check("div_min_clamp", 64'(d), 64'h2);
    avl_wr(A_DIV, 32'h0000_1234, 4'b0010);
    avl_rd(A_DIV, d, v);
    check("div_lane1", 64'(d), 64'h1202);
    avl_rd(A_RSVD, d, v);
    check("rsvd_read", 64'(d), 64'h0);

    // TX frame of 0xA5 at DIV=4
    avl_wr(A_DIV, 32'd4, 4'hF);
    avl_wr(A_DATA, 32'hA5, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) found = 1'b1;
    end
    check("tx_start_seen", 64'(found), 64'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 40; j++) txe[j] = frame[j/4];
    fork
      begin
        txs[0] = uart_txd;
        for (int j = 1; j < 40; j++) begin
          @(negedge clk);
          txs[j] = uart_txd;
        end
      end
      begin
        repeat (9) @(negedge clk);
        avl_rd(A_STATUS, d2, v);
        check("tx_status_busy", 64'(d2), 64'h46);
      end
    join
    check("tx_waveform", 64'(txs), 64'(txe));
    avl_rd(A_STATUS, d, v);
    check("tx_status_idle", 64'(d), 64'h06);

    // Loopback receive of 0x3C at DIV=8
    avl_wr(A_DIV, 32'd8, 4'hF);
    loop_en = 1'b1;
    avl_wr(A_DATA, 32'h3C, 4'h1);
    repeat (130) @(negedge clk);
    avl_rd(A_DATA, d, v);
    check("rx_loop_byte", 64'(d), 64'h13C);
    avl_rd(A_DATA, d, v);
    check("rx_loop_empty", 64'(d), 64'h0);

    // Overrun: 17 bytes into a 16-deep RX FIFO
    avl_wr(A_DIV, 32'd4, 4'hF);
    for (int i = 0; i < 17; i++) avl_wr(A_DATA, 32'h10 + 32'(i), 4'h1);
    repeat (760) @(negedge clk);
    avl_rd(A_STATUS, d, v);
    check("ovr_status_set", 64'(d), 64'h1A);
    avl_rd(A_STATUS, d, v);
    check("ovr_status_clr", 64'(d), 64'h0A);
    for (int i = 0; i < 16; i++) begin
      avl_rd(A_DATA, d, v);
      check($sformatf("ovr_byte%0d", i), 64'(d), 64'h110 + 64'(i));
    end
    avl_rd(A_DATA, d, v);
    check("ovr_drained", 64'(d), 64'h0);

    // Frame error: stop bit driven low
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    bad_frame = {1'b0, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd_drv = bad_frame[k];
      repeat (4) @(negedge clk);
    end
    rxd_drv = 1'b1;
    repeat (20) @(negedge clk);
    avl_rd(A_STATUS, d, v);
    check("frame_status_set", 64'(d), 64'h26);
    avl_rd(A_STATUS, d, v);
    check("frame_status_clr", 64'(d), 64'h06);
    avl_rd(A_DATA, d, v);
    check("frame_discard", 64'(d), 64'h0);

    // Interrupt on RX data
    avl_wr(A_CTRL, 32'h7, 4'hF);
    repeat (2) @(negedge clk);
    check("irq_rx_empty", 64'(irq), 64'd0);
    loop_en = 1'b1;
    avl_wr(A_DATA, 32'h81, 4'h1);
    repeat (60) @(negedge clk);
    check("irq_rx_data", 64'(irq), 64'd1);
    avl_rd(A_DATA, d, v);
    check("irq_byte", 64'(d), 64'h181);
    repeat (2) @(negedge clk);
    check("irq_after_pop", 64'(irq), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
